// File: rtl/wb_regfile.sv
// Write-back register file: commits the MEM/WB result, serves two registered
// read ports with write-to-read bypass, and zeroes every entry after reset.
module wb_regfile #(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ZERO_REG           = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          wb_valid,
    input  logic                          wb_sel_mem,
    input  logic [DATAPATH_WIDTH-1:0]     mem_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     accum_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATAPATH_WIDTH-1:0]     rd_data_a,
    output logic [DATAPATH_WIDTH-1:0]     rd_data_b,
    output logic                          busy
);

    localparam int DEPTH    = 1 << REGFILE_ADDR_WIDTH;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                          state;
    state_t                          next_state;
    logic [REGFILE_ADDR_WIDTH-1:0]   clear_ptr;
    logic [DATAPATH_WIDTH-1:0]       regs [DEPTH];

    logic                            commit;
    logic [DATAPATH_WIDTH-1:0]       wdata;
    logic                            arr_we;
    logic [REGFILE_ADDR_WIDTH-1:0]   arr_waddr;
    logic [DATAPATH_WIDTH-1:0]       arr_wdata;
    logic [DATAPATH_WIDTH-1:0]       next_a;
    logic [DATAPATH_WIDTH-1:0]       next_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (en && (&clear_ptr)) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = CLEAR;
        endcase
    end

    // The single array write port is shared between the sweep and commits;
    // nothing is written on the reset edge itself.
    always_comb begin
        busy      = (state == CLEAR);
        wdata     = wb_sel_mem ? mem_data_in : accum_in;
        commit    = (state == RUN) && en && wb_valid &&
                    !(HAS_ZERO && (WR_addr_in == '0));
        arr_we    = 1'b0;
        arr_waddr = WR_addr_in;
        arr_wdata = wdata;
        if (!reset) begin
            if ((state == CLEAR) && en) begin
                arr_we    = 1'b1;
                arr_waddr = clear_ptr;
                arr_wdata = '0;
            end else if (commit) begin
                arr_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_ptr <= '0;
        end else if ((state == CLEAR) && en) begin
            clear_ptr <= clear_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            regs[arr_waddr] <= arr_wdata;
        end
    end

    always_comb begin
        next_a = regs[rd_addr_a];
        if (commit && (WR_addr_in == rd_addr_a)) next_a = wdata;
        if (HAS_ZERO && (rd_addr_a == '0)) next_a = '0;
        next_b = regs[rd_addr_b];
        if (commit && (WR_addr_in == rd_addr_b)) next_b = wdata;
        if (HAS_ZERO && (rd_addr_b == '0)) next_b = '0;
    end

    always_ff @(posedge clk) begin
        if (reset || (state == CLEAR)) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (en) begin
            rd_data_a <= next_a;
            rd_data_b <= next_b;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: two instances (zero register on and off)
// share stimulus and are compared against an array-based reference model.
module tb_wb_regfile;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset;
    logic          en;
    logic          wb_valid;
    logic          wb_sel_mem;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] accum_in;
    logic [AW-1:0] WR_addr_in;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          busy;
    logic [DW-1:0] rd_data_a_nz;
    logic [DW-1:0] rd_data_b_nz;
    logic          busy_nz;

    wb_regfile #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .en(en), .wb_valid(wb_valid), .wb_sel_mem(wb_sel_mem),
        .mem_data_in(mem_data_in), .accum_in(accum_in), .WR_addr_in(WR_addr_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .busy(busy)
    );

    wb_regfile #(.DATAPATH_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .en(en), .wb_valid(wb_valid), .wb_sel_mem(wb_sel_mem),
        .mem_data_in(mem_data_in), .accum_in(accum_in), .WR_addr_in(WR_addr_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a_nz), .rd_data_b(rd_data_b_nz), .busy(busy_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic [DW-1:0] a_z;
        logic [DW-1:0] b_z;
        logic [DW-1:0] a_nz;
        logic [DW-1:0] b_nz;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_z  [DEPTH];
    logic [DW-1:0] model_nz [DEPTH];
    int            sweep_left = 0;
    exp_t          cur;
    int            check_count = 0;
    int            pass_count  = 0;

    // Reference model: the register file is a plain array, the sweep is a
    // countdown of entries still to clear, and a read sees the array after
    // this cycle's write (which is what bypass means).
    task automatic applyStimulus(input logic rst, input logic e, input logic v,
                                 input logic sel, input logic [DW-1:0] md,
                                 input logic [DW-1:0] acc, input logic [AW-1:0] wr,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        logic [DW-1:0] data;
        @(negedge clk);
        reset = rst; en = e; wb_valid = v; wb_sel_mem = sel;
        mem_data_in = md; accum_in = acc; WR_addr_in = wr;
        rd_addr_a = ra; rd_addr_b = rb;
        if (rst) begin
            sweep_left = DEPTH;
            cur.a_z = '0; cur.b_z = '0; cur.a_nz = '0; cur.b_nz = '0;
        end else if (sweep_left > 0) begin
            if (e) begin
                model_z[DEPTH - sweep_left]  = '0;
                model_nz[DEPTH - sweep_left] = '0;
                sweep_left--;
            end
            cur.a_z = '0; cur.b_z = '0; cur.a_nz = '0; cur.b_nz = '0;
        end else if (e) begin
            if (v) begin
                data = sel ? md : acc;
                if (wr != 0) model_z[wr] = data;
                model_nz[wr] = data;
            end
            cur.a_z  = (ra == 0) ? '0 : model_z[ra];
            cur.b_z  = (rb == 0) ? '0 : model_z[rb];
            cur.a_nz = model_nz[ra];
            cur.b_nz = model_nz[rb];
        end
        cur.busy = (sweep_left > 0);
        sb.push_back(cur);
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idleRead(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, ra, rb);
    endtask

    task automatic commitRead(input logic sel, input logic [DW-1:0] md, input logic [DW-1:0] acc,
                              input logic [AW-1:0] wr, input logic [AW-1:0] ra,
                              input logic [AW-1:0] rb);
        applyStimulus(1'b0, 1'b1, 1'b1, sel, md, acc, wr, ra, rb);
    endtask

    // Sweep runs with en held high while trying to commit 0xAA into entry 5.
    task automatic finishSweep();
        int guard = 0;
        while (sweep_left > 0 && guard < 4 * DEPTH) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 64'hAA, 5'd5,
                          AW'($urandom), AW'($urandom));
            guard++;
        end
        if (sweep_left > 0) begin
            check_count++;
            $display("[TB] FAIL sweep_bound: got %0d left, expected 0", sweep_left);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                checkOutput("busy",      DW'(busy),    DW'(x.busy));
                checkOutput("busy_nz",   DW'(busy_nz), DW'(x.busy));
                checkOutput("rd_a",      rd_data_a,    x.a_z);
                checkOutput("rd_b",      rd_data_b,    x.b_z);
                checkOutput("rd_a_nz",   rd_data_a_nz, x.a_nz);
                checkOutput("rd_b_nz",   rd_data_b_nz, x.b_nz);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; wb_valid = 1'b0; wb_sel_mem = 1'b0;
        mem_data_in = '0; accum_in = '0; WR_addr_in = '0; rd_addr_a = '0; rd_addr_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_z[i] = '0;
            model_nz[i] = '0;
        end

        doReset();
        finishSweep();
        for (int i = 0; i < DEPTH; i++) idleRead(AW'(i), AW'(DEPTH - 1 - i));

        commitRead(1'b0, '0, 64'h1234, 5'd3, 5'd1, 5'd2);
        commitRead(1'b1, 64'hDEAD_BEEF_0000_0001, '0, 5'd4, 5'd1, 5'd2);
        idleRead(5'd3, 5'd4);
        idleRead(5'd4, 5'd3);

        commitRead(1'b0, '0, 64'h55, 5'd7, 5'd7, 5'd7);
        commitRead(1'b0, '0, 64'hFFFF, 5'd0, 5'd0, 5'd3);
        idleRead(5'd0, 5'd0);

        // Stall: frozen outputs, dropped commit, then check entry 9.
        idleRead(5'd4, 5'd9);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd3, 5'd7);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 64'h77, 5'd9, 5'd9, 5'd9);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h77, 64'h77, 5'd9, 5'd11, 5'd9);
        idleRead(5'd9, 5'd4);

        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] wr;
            wr = AW'($urandom);
            applyStimulus(1'b0, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom}, wr,
                          ($urandom_range(0, 2) == 0) ? wr : AW'($urandom),
                          ($urandom_range(0, 2) == 0) ? wr : AW'($urandom));
        end

        // Sweep with en dropped for 5 cycles in the middle.
        doReset();
        for (int i = 0; i < 10; i++) idleRead(AW'(i), AW'(i));
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 64'h3, 5'd2, 5'd2, 5'd2);
        finishSweep();
        for (int i = 0; i < DEPTH; i++) idleRead(AW'(i), AW'(i));

        commitRead(1'b0, '0, 64'h99, 5'd31, 5'd31, 5'd30);
        idleRead(5'd31, 5'd31);
        doReset();
        for (int i = 0; i < 10; i++) idleRead(5'd31, 5'd31);
        doReset();
        finishSweep();
        idleRead(5'd31, 5'd31);

        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] wr;
            wr = AW'($urandom);
            applyStimulus(1'b0, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom}, wr,
                          ($urandom_range(0, 2) == 0) ? wr : AW'($urandom),
                          AW'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
